frame_buffer_ex_lfsr8_checker: RTL

//  Receive-side pattern checker for the 8-bit frame-buffer test LFSR. Consumes bytes read back

---
 rtl/frame_buffer_ex_lfsr8_checker.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/frame_buffer_ex_lfsr8_checker.sv
// ---------------------------------------------------------------------------
// frame_buffer_ex_lfsr8_checker
//
// Purpose:
//   Receive-side pattern checker for the 8-bit frame-buffer test LFSR
//   (x^8+x^4+x^3+x^2+1, Galois form). It regenerates the expected byte
//   sequence, compares it against the bytes read back from the frame buffer
//   and counts mismatches. With SELF_SYNC=1 the first nonzero valid byte seeds
//   the checker, so it can lock onto a stream with an unknown start.
//
// Optional feature (macro FB_LFSR8_CHK_CAPTURE_EN):
//   When defined, first_err_valid/exp/got/idx capture the first mismatch seen
//   since reset or enable=0. When undefined, those ports and registers are absent.
//
// Ports:
//   clk          in   1      clock
//   reset_n      in   1      asynchronous active-low reset
//   enable       in   1      0: idle/clear, 1: run (overrides in_valid)
//   in_valid     in   1      in_data valid this cycle; low holds all state
//   in_data      in   8      received byte
//   locked       out  1      checker is in CHECK state
//   err_pulse    out  1      one-cycle pulse per mismatched beat
//   error_count  out  ERR_W  saturating mismatch count
//   word_count   out  32     compared beats, wraps
//   expected     out  8      value the next beat is compared against
//   first_err_*  out  -      first-mismatch capture (FB_LFSR8_CHK_CAPTURE_EN only)
// ---------------------------------------------------------------------------
module frame_buffer_ex_lfsr8_checker #(
  parameter logic [31:0] SEED        = 32'd32,
  parameter bit          SELF_SYNC   = 1'b0,
  parameter int          LOSS_THRESH = 4,
  parameter int          ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] error_count,
  output logic [31:0]      word_count,
`ifdef FB_LFSR8_CHK_CAPTURE_EN
  output logic             first_err_valid,
  output logic [7:0]       first_err_exp,
  output logic [7:0]       first_err_got,
  output logic [31:0]      first_err_idx,
`endif
  output logic [7:0]       expected
);

  localparam logic [7:0]       SEED8    = SEED[7:0];
  localparam logic [7:0]       LOSS_T   = LOSS_THRESH[7:0];
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t           state_reg;
  logic [7:0]       expected_reg;
  logic             locked_reg;
  logic             err_pulse_reg;
  logic [ERR_W-1:0] error_count_reg;
  logic [31:0]      word_count_reg;
  logic [7:0]       miss_run_reg;

`ifdef FB_LFSR8_CHK_CAPTURE_EN
  logic             first_err_valid_reg;
  logic [7:0]       first_err_exp_reg;
  logic [7:0]       first_err_got_reg;
  logic [31:0]      first_err_idx_reg;
`endif

  // One Galois step: shift left, feed x7 back into bit 0 and taps 2,3,4.
  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ ({8{x[7]}} & 8'h1D);
  endfunction

  logic       mismatch;
  logic [7:0] miss_run_inc;

  assign mismatch     = (in_data != expected_reg);
  // Saturate so a non-syncing checker cannot wrap back onto the threshold.
  assign miss_run_inc = (miss_run_reg == 8'hFF) ? 8'hFF : miss_run_reg + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      expected_reg    <= SEED8;
      locked_reg      <= 1'b0;
      err_pulse_reg   <= 1'b0;
      error_count_reg <= '0;
      word_count_reg  <= '0;
      miss_run_reg    <= '0;
`ifdef FB_LFSR8_CHK_CAPTURE_EN
      first_err_valid_reg <= 1'b0;
      first_err_exp_reg   <= '0;
      first_err_got_reg   <= '0;
      first_err_idx_reg   <= '0;
`endif
    end else if (!enable) begin
      // Disabling clears everything, and a beat presented this cycle is dropped.
      state_reg       <= IDLE;
      expected_reg    <= SEED8;
      locked_reg      <= 1'b0;
      err_pulse_reg   <= 1'b0;
      error_count_reg <= '0;
      word_count_reg  <= '0;
      miss_run_reg    <= '0;
`ifdef FB_LFSR8_CHK_CAPTURE_EN
      first_err_valid_reg <= 1'b0;
      first_err_exp_reg   <= '0;
      first_err_got_reg   <= '0;
      first_err_idx_reg   <= '0;
`endif
    end else begin
      err_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // The enabling cycle only starts the FSM; no beat is consumed.
          miss_run_reg <= '0;
          if (SELF_SYNC) begin
            state_reg  <= ACQUIRE;
            locked_reg <= 1'b0;
          end else begin
            state_reg  <= CHECK;
            locked_reg <= 1'b1;
          end
        end

        ACQUIRE: begin
          // 0x00 is the LFSR lock-up value and can never seed a valid sequence.
          if (in_valid && (in_data != 8'h00)) begin
            expected_reg <= lfsr_step(in_data);
            state_reg    <= CHECK;
            locked_reg   <= 1'b1;
            miss_run_reg <= '0;
          end
        end

        CHECK: begin
          if (in_valid) begin
            word_count_reg <= word_count_reg + 32'd1;
            // Advance regardless of the result: a single bad byte must not
            // knock the checker off the sequence.
            expected_reg   <= lfsr_step(expected_reg);
            if (mismatch) begin
              err_pulse_reg <= 1'b1;
              if (error_count_reg != ERR_MAX)
                error_count_reg <= error_count_reg + 1'b1;
              if (SELF_SYNC && (miss_run_inc == LOSS_T)) begin
                state_reg    <= ACQUIRE;
                locked_reg   <= 1'b0;
                miss_run_reg <= '0;
              end else begin
                miss_run_reg <= miss_run_inc;
              end
`ifdef FB_LFSR8_CHK_CAPTURE_EN
              if (!first_err_valid_reg) begin
                first_err_valid_reg <= 1'b1;
                first_err_exp_reg   <= expected_reg;
                first_err_got_reg   <= in_data;
                first_err_idx_reg   <= word_count_reg;
              end
`endif
            end else begin
              miss_run_reg <= '0;
            end
          end
        end

        default: begin
          state_reg  <= IDLE;
          locked_reg <= 1'b0;
        end
      endcase
    end
  end

  assign locked      = locked_reg;
  assign err_pulse   = err_pulse_reg;
  assign error_count = error_count_reg;
  assign word_count  = word_count_reg;
  assign expected    = expected_reg;

`ifdef FB_LFSR8_CHK_CAPTURE_EN
  assign first_err_valid = first_err_valid_reg;
  assign first_err_exp   = first_err_exp_reg;
  assign first_err_got   = first_err_got_reg;
  assign first_err_idx   = first_err_idx_reg;
`endif

endmodule
